muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit and controller for the pipelined MIPS core. Executes mult, multu, div and divu, and owns the HI/LO registers.
- Sits beside the EX-stage ALU. The pipeline control unit issues operations to it and stalls on `busy`.
- Also serves mthi/mtlo writes and supplies HI/LO read data for mfhi/mflo.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. Iteration count equals DATA_WIDTH.
- CNT_WIDTH, 6, iteration counter width. Must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue request, sampled at rising edge.
- op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- op_a  input  DATA_WIDTH  rs operand (multiplicand / dividend).
- op_b  input  DATA_WIDTH  rt operand (multiplier / divisor).
- flush  input  1  squash the in-flight operation (exception or branch kill).
- hi_we  input  1  mthi write enable.
- lo_we  input  1  mtlo write enable.
- wdata  input  DATA_WIDTH  mthi/mtlo data.
- busy  output  1  operation in flight; the pipeline stalls on any mult/div/mfhi/mflo while this is high.
- done  output  1  one-cycle pulse, HI/LO newly valid.
- hi  output  DATA_WIDTH  HI register.
- lo  output  DATA_WIDTH  LO register.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal shift registers=0.
- FSM states: IDLE, COMPUTE, FINISH.
- IDLE:
  - On start=1 and flush=0 at edge E0: latch op. Latch |op_a| and |op_b| (two's-complement magnitude for signed ops, raw value for unsigned). Latch result-sign flags. Counter=0. Next state COMPUTE.
  - start while flush=1 is dropped.
- COMPUTE: one iteration per edge.
  - Multiply: shift-add. If product LSB=1, add multiplicand to the upper half, then shift the 2*DATA_WIDTH accumulator right by 1.
  - Divide: restoring. Shift the {rem,quo} pair left by 1. Trial-subtract the divisor from rem. If the result is non-negative, keep it and set quo LSB.
  - After DATA_WIDTH iterations (edge E32 at default) go to FINISH.
- FINISH: at edge E33, apply sign fix-up and write HI/LO, then go to IDLE.
  - mult/multu: {hi,lo}=product. Negate the 64-bit product for mult when operand signs differ.
  - div/divu: lo=quotient, hi=remainder. For div, negate the quotient if signs differ; the remainder takes the dividend's sign.
- done=1 for exactly the one cycle after the HI/LO write (busy=0 in that cycle). Otherwise done=0.
- busy=1 in COMPUTE and FINISH. Total: 33 busy cycles, and the result is visible 33 edges after the accepting edge.
- start while busy=1 is ignored. Control must not issue it; an assertion flags it.
- Divide by zero: lo=all ones, hi=op_a. This applies to both div and divu; sign fix-up is skipped.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- flush in COMPUTE or FINISH: next edge goes to IDLE, busy=0, done stays 0, HI/LO are unchanged.
- flush has priority over the FINISH write and over start.
- hi_we/lo_we:
  - Accepted only in IDLE with start=0. hi/lo take wdata at that edge.
  - Ignored while busy=1.
  - If start and a write coincide in IDLE, start wins and the write is dropped. Control serialises these.
- reset mid-operation returns everything to reset values at that edge.

Optional Feature:
- MULDIV_FAST_MULT_EN
- Defined: mult/multu use a single-cycle combinational multiplier. IDLE goes straight to FINISH, so busy=1 for 1 cycle and the result is written at E1, with done in the following cycle. Divide timing is unchanged.
- Undefined: all operations use the 32-iteration path above.

Test Plan:
- After reset, check hi=lo=0 and busy=done=0. Then multu 0xFFFFFFFF*0xFFFFFFFF -> busy high 33 cycles, hi=0xFFFFFFFE, lo=0x00000001, done single pulse.
- mult 0xFFFFFFFD(-3)*0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 100/0 -> lo=0xFFFFFFFF, hi=0x00000064. Then div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start divu 50/7, assert flush at cycle 10 -> busy drops the next cycle, no done pulse, HI/LO keep their prior values. Issue divu 50/7 again -> lo=7, hi=1.
- hi_we=1 with wdata=0x1234 while busy -> ignored. hi_we=1 with wdata=0x1234 in IDLE -> hi=0x1234 the next cycle. start+lo_we in the same cycle -> lo holds the op result only.
- With MULDIV_FAST_MULT_EN defined: mult 6*7 -> busy 1 cycle, lo=42, hi=0. divu timing still 33 busy cycles.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the pipeline control unit and the mult/div sequencer.
// Control drives requests and mthi/mtlo writes; the sequencer returns status and HI/LO.
interface muldiv_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  flush;
    logic                  hi_we;
    logic                  lo_we;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output start, op, op_a, op_b, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, op_a, op_b, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative mult/multu/div/divu unit owning HI/LO for the MIPS EX stage.
// Define MULDIV_FAST_MULT_EN to make mult/multu single-cycle; divide timing is unaffected.
//
// state   | meaning
// IDLE    | waiting for start; mthi/mtlo writes accepted here
// COMPUTE | one shift-add / restoring-divide iteration per clock
// FINISH  | sign fix-up and HI/LO write
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input logic              clk,
    input logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2*W-1:0]       acc;
    logic [W-1:0]         mcand;
    logic [1:0]           op_q;
    logic                 neg_res, neg_rem, div0;
    logic                 done_q;
    logic [W-1:0]         hi_q, lo_q;
    logic                 busy_c, accept, iterate, write_res, mt_ok;

    logic                 is_signed;
    logic [W-1:0]         abs_a, abs_b;
    logic [W:0]           mul_sum, div_diff;
    logic [2*W-1:0]       acc_nx, prod_raw, prod;
    logic [W-1:0]         quo, rem, hi_res, lo_res;

    assign is_signed = ~bus.op[0];
    assign abs_a     = (is_signed && bus.op_a[W-1]) ? -bus.op_a : bus.op_a;
    assign abs_b     = (is_signed && bus.op_b[W-1]) ? -bus.op_b : bus.op_b;

    // acc holds {partial product, multiplier} for multiply, {rem, quo} for divide
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        div_diff = acc[2*W-1:W-1] - {1'b0, mcand};
        acc_nx   = acc;
        if (!op_q[1])
            acc_nx = {mul_sum, acc[W-1:1]};
        else if (!div_diff[W])
            acc_nx = {div_diff[W-1:0], acc[W-2:0], 1'b1};
        else
            acc_nx = {acc[2*W-2:0], 1'b0};
    end

    // A zero divisor leaves rem=|op_a| and quo=all ones, so the remainder fix-up reproduces op_a
    always_comb begin
`ifdef MULDIV_FAST_MULT_EN
        prod_raw = {{W{1'b0}}, mcand} * {{W{1'b0}}, acc[W-1:0]};
`else
        prod_raw = acc;
`endif
        prod = neg_res ? -prod_raw : prod_raw;
        quo  = acc[W-1:0];
        rem  = acc[2*W-1:W];
        if (op_q[1]) begin
            lo_res = div0 ? {W{1'b1}} : (neg_res ? -quo : quo);
            hi_res = neg_rem ? -rem : rem;
        end else begin
            lo_res = prod[W-1:0];
            hi_res = prod[2*W-1:W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
`ifdef MULDIV_FAST_MULT_EN
                    state_nx = bus.op[1] ? COMPUTE : FINISH;
`else
                    state_nx = COMPUTE;
`endif
                end
            end
            COMPUTE: begin
                if (bus.flush)                          state_nx = IDLE;
                else if (cnt == CNT_WIDTH'(W - 1))      state_nx = FINISH;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_c    = (state != IDLE);
        accept    = (state == IDLE) && bus.start && !bus.flush;
        iterate   = (state == COMPUTE) && !bus.flush;
        write_res = (state == FINISH) && !bus.flush;
        mt_ok     = (state == IDLE) && !bus.start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            op_q    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= write_res;
            if (accept) begin
                op_q    <= bus.op;
                cnt     <= '0;
                neg_res <= is_signed & (bus.op_a[W-1] ^ bus.op_b[W-1]);
                neg_rem <= is_signed & bus.op_a[W-1];
                div0    <= (bus.op_b == '0);
                if (bus.op[1]) begin
                    acc   <= {{W{1'b0}}, abs_a};
                    mcand <= abs_b;
                end else begin
                    acc   <= {{W{1'b0}}, abs_b};
                    mcand <= abs_a;
                end
            end
            if (iterate) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
            end
            if (write_res) begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end
            if (mt_ok && bus.hi_we) hi_q <= bus.wdata;
            if (mt_ok && bus.lo_we) lo_q <= bus.wdata;
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Control must hold off new operations while one is in flight
    a_no_start_busy: assert property (@(posedge clk) disable iff (reset) !(bus.start && busy_c));
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table for results and timing,
// hand sequences for flush, mthi/mtlo arbitration and mid-operation reset.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.DATA_WIDTH(W)) bus();

    muldiv_sequencer #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_busy(input logic [1:0] op);
`ifdef MULDIV_FAST_MULT_EN
        if (!op[1]) return 1;
`endif
        return 33;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy, output logic early, output logic pulse, output logic after);
        nbusy = 0;
        early = 1'b0;
        @(negedge clk);
        while (bus.busy && nbusy < 100) begin
            nbusy++;
            if (bus.done) early = 1'b1;
            @(negedge clk);
        end
        pulse = bus.done;
        @(negedge clk);
        after = bus.done;
    endtask

    task automatic mt_write(input logic hw, input logic lw, input logic [31:0] d);
        @(negedge clk);
        bus.hi_we = hw;
        bus.lo_we = lw;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nb;
        logic early, pulse, after;

        vecs[0]  = '{"multu max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult -3*7",   2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{"div -7/2",    2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu 100/0",  2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[4]  = '{"div ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"divu 50/7",   2'b11, 32'h00000032, 32'h00000007, 32'h00000001, 32'h00000007};
        vecs[6]  = '{"mult 6*7",    2'b00, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A};
        vecs[7]  = '{"div 7/-2",    2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{"div -100/0",  2'b10, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF};
        vecs[9]  = '{"multu 2^32",  2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[10] = '{"mult -5*-6",  2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E};

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.flush = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset hi", bus.hi, 32'h0);
        check("reset lo", bus.lo, 32'h0);
        check("reset busy", {31'b0, bus.busy}, 32'h0);
        check("reset done", {31'b0, bus.done}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(nb, early, pulse, after);
            check($sformatf("%s busy cycles", vecs[i].name), nb, exp_busy(vecs[i].op));
            check($sformatf("%s done early", vecs[i].name), {31'b0, early}, 32'h0);
            check($sformatf("%s done pulse", vecs[i].name), {31'b0, pulse}, 32'h1);
            check($sformatf("%s done width", vecs[i].name), {31'b0, after}, 32'h0);
            check($sformatf("%s hi", vecs[i].name), bus.hi, vecs[i].ehi);
            check($sformatf("%s lo", vecs[i].name), bus.lo, vecs[i].elo);
        end

        // mthi / mtlo in IDLE
        mt_write(1'b1, 1'b0, 32'h00001234);
        @(negedge clk);
        check("mthi idle hi", bus.hi, 32'h00001234);
        check("mthi idle lo", bus.lo, 32'h0000001E);
        mt_write(1'b0, 1'b1, 32'h00005678);
        @(negedge clk);
        check("mtlo idle lo", bus.lo, 32'h00005678);

        // flush in COMPUTE
        issue(2'b11, 32'd50, 32'd7);
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("flush busy", {31'b0, bus.busy}, 32'h0);
        check("flush done", {31'b0, bus.done}, 32'h0);
        @(negedge clk);
        check("flush done later", {31'b0, bus.done}, 32'h0);
        check("flush hi kept", bus.hi, 32'h00001234);
        check("flush lo kept", bus.lo, 32'h00005678);

        issue(2'b11, 32'd50, 32'd7);
        wait_done(nb, early, pulse, after);
        check("reissue busy cycles", nb, 33);
        check("reissue hi", bus.hi, 32'd1);
        check("reissue lo", bus.lo, 32'd7);

        // flush arriving in FINISH beats the write
        issue(2'b11, 32'd100, 32'd3);
        repeat (32) @(posedge clk);
        #1;
        check("finish still busy", {31'b0, bus.busy}, 32'h1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("finish flush busy", {31'b0, bus.busy}, 32'h0);
        check("finish flush done", {31'b0, bus.done}, 32'h0);
        check("finish flush hi", bus.hi, 32'd1);
        check("finish flush lo", bus.lo, 32'd7);

        // mthi while busy is ignored
        issue(2'b11, 32'd15, 32'd4);
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000BEEF;
        @(posedge clk);
        #1 bus.hi_we = 1'b0;
        @(negedge clk);
        check("mthi busy ignored", bus.hi, 32'd1);
        wait_done(nb, early, pulse, after);
        check("divu 15/4 hi", bus.hi, 32'd3);
        check("divu 15/4 lo", bus.lo, 32'd3);

        // start and mtlo together: start wins
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.op_a  = 32'd2;
        bus.op_b  = 32'd3;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000DEAD;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        @(negedge clk);
        check("start+mtlo lo held", bus.lo, 32'd3);
        wait_done(nb, early, pulse, after);
        check("start+mtlo busy cycles", nb + 1, exp_busy(2'b01));
        check("start+mtlo lo", bus.lo, 32'd6);
        check("start+mtlo hi", bus.hi, 32'd0);

        // start with flush in IDLE is dropped
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 2'b11;
        bus.op_a  = 32'd9;
        bus.op_b  = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        check("start+flush busy", {31'b0, bus.busy}, 32'h0);
        @(negedge clk);
        check("start+flush done", {31'b0, bus.done}, 32'h0);
        check("start+flush lo", bus.lo, 32'd6);

        // reset mid-operation
        issue(2'b11, 32'd9, 32'd2);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midreset busy", {31'b0, bus.busy}, 32'h0);
        check("midreset hi", bus.hi, 32'h0);
        check("midreset lo", bus.lo, 32'h0);

        issue(2'b10, 32'hFFFFFFF9, 32'd2);
        wait_done(nb, early, pulse, after);
        check("post-reset div busy", nb, 33);
        check("post-reset div lo", bus.lo, 32'hFFFFFFFD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
